// File: rtl/adc_touch_if.sv
// Serial bus between a touch-screen controller (master) and the
// ADS7843-style ADC it talks to (slave).
interface adc_touch_if;
  logic ADC_DCLK;
  logic ADC_CS;
  logic ADC_DIN;
  logic ADC_DOUT;
  logic ADC_BUSY;
  logic ADC_PENIRQ_n;

  modport master (
    output ADC_DCLK, ADC_CS, ADC_DIN,
    input  ADC_DOUT, ADC_BUSY, ADC_PENIRQ_n
  );

  modport slave (
    input  ADC_DCLK, ADC_CS, ADC_DIN,
    output ADC_DOUT, ADC_BUSY, ADC_PENIRQ_n
  );
endinterface

// File: rtl/adc_touch_responder.sv
// Stand-in for an external ADS7843-style touch ADC: decodes control bytes,
// answers with an X/Y coordinate on DOUT and drives BUSY and PENIRQ_n.
module adc_touch_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] X_CHANNEL   = 3'b001,
  parameter logic [2:0] Y_CHANNEL   = 3'b101,
  parameter logic       CS_ACTIVE   = 1'b1
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  adc_touch_if.slave  adc,
  input  logic        iPEN_DOWN,
  input  logic [11:0] iX_POS,
  input  logic [11:0] iY_POS,
  output logic [7:0]  oCMD,
  output logic        oCMD_VALID
);

  typedef enum logic {CWAIT, COLLECT} colState_t;
  typedef enum logic [2:0] {OIDLE, ARM, BUSY, SHIFT, TAIL} outState_t;

  logic [SYNC_STAGES-1:0] dclkSync, csSync, dinSync;
  logic                   dclkPrev;
  logic                   dclkNow, dinNow, selected, rise, fall;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      dclkSync <= '0;
      csSync   <= {SYNC_STAGES{~CS_ACTIVE}};
      dinSync  <= '0;
      dclkPrev <= 1'b0;
    end else begin
      dclkSync <= {dclkSync[SYNC_STAGES-2:0], adc.ADC_DCLK};
      csSync   <= {csSync[SYNC_STAGES-2:0], adc.ADC_CS};
      dinSync  <= {dinSync[SYNC_STAGES-2:0], adc.ADC_DIN};
      dclkPrev <= dclkSync[SYNC_STAGES-1];
    end
  end

  // Edges only count while selected, so a deselect on the same cycle wins.
  assign dclkNow  = dclkSync[SYNC_STAGES-1];
  assign dinNow   = dinSync[SYNC_STAGES-1];
  assign selected = (csSync[SYNC_STAGES-1] == CS_ACTIVE);
  assign rise     = selected &  dclkNow & ~dclkPrev;
  assign fall     = selected & ~dclkNow &  dclkPrev;

  // ---------------- command collector ----------------
  colState_t   colState, colNext;
  logic [2:0]  bitCnt;
  logic [6:0]  cmdShift;
  logic [7:0]  cmdByte;
  logic        capture;
  logic        irqEn;

  assign cmdByte = {cmdShift, dinNow};
  assign capture = (colState == COLLECT) && rise && (bitCnt == 3'd7);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    colNext = colState;
    if (!selected) begin
      colNext = CWAIT;
    end else begin
      case (colState)
        CWAIT:   if (rise && dinNow) colNext = COLLECT;
        COLLECT: if (capture)        colNext = CWAIT;
        default: colNext = CWAIT;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      colState   <= CWAIT;
      bitCnt     <= 3'd0;
      cmdShift   <= 7'd0;
      oCMD       <= 8'd0;
      oCMD_VALID <= 1'b0;
      irqEn      <= 1'b1;
    end else begin
      colState   <= colNext;
      oCMD_VALID <= capture;
      if (colState == CWAIT && rise && dinNow) begin
        bitCnt   <= 3'd1;
        cmdShift <= 7'd1;
      end else if (colState == COLLECT && rise) begin
        bitCnt   <= bitCnt + 3'd1;
        cmdShift <= {cmdShift[5:0], dinNow};
      end
      if (capture) begin
        oCMD  <= cmdByte;
        irqEn <= ~dinNow;
      end
    end
  end

  // ---------------- result shifter ----------------
  outState_t   outState, outNext;
  logic [11:0] outShift, shiftNext, snapData, snapLoad;
  logic [3:0]  outCnt, cntNext;
  logic        dout, doutNext, busy, busyNext, penIrq_n;

  // 8-bit mode is the top byte left-aligned, so one MSB-first shifter serves both.
  always_comb begin
    snapData = 12'h000;
    if (cmdByte[6:4] == X_CHANNEL)      snapData = iX_POS;
    else if (cmdByte[6:4] == Y_CHANNEL) snapData = iY_POS;
    snapLoad = cmdByte[3] ? {snapData[11:4], 4'h0} : snapData;
  end

  always_comb begin
    outNext   = outState;
    shiftNext = outShift;
    cntNext   = outCnt;
    doutNext  = dout;
    busyNext  = busy;
    if (!selected) begin
      outNext  = OIDLE;
      doutNext = 1'b0;
      busyNext = 1'b0;
    end else if (capture) begin
      outNext   = ARM;
      shiftNext = snapLoad;
      cntNext   = cmdByte[3] ? 4'd7 : 4'd11;
    end else if (fall) begin
      case (outState)
        ARM: begin
          busyNext = 1'b1;
          doutNext = 1'b0;
          outNext  = BUSY;
        end
        BUSY: begin
          busyNext  = 1'b0;
          doutNext  = outShift[11];
          shiftNext = {outShift[10:0], 1'b0};
          outNext   = SHIFT;
        end
        SHIFT: begin
          if (outCnt != 4'd0) begin
            doutNext  = outShift[11];
            shiftNext = {outShift[10:0], 1'b0};
            cntNext   = outCnt - 4'd1;
          end else begin
            doutNext = 1'b0;
            outNext  = TAIL;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      outState <= OIDLE;
      outShift <= 12'h000;
      outCnt   <= 4'd0;
      dout     <= 1'b0;
      busy     <= 1'b0;
      penIrq_n <= 1'b1;
    end else begin
      outState <= outNext;
      outShift <= shiftNext;
      outCnt   <= cntNext;
      dout     <= doutNext;
      busy     <= busyNext;
      penIrq_n <= ~(iPEN_DOWN & irqEn &
                    ~((colState == COLLECT) || (outState inside {ARM, BUSY, SHIFT})));
    end
  end

  assign adc.ADC_DOUT     = dout;
  assign adc.ADC_BUSY     = busy;
  assign adc.ADC_PENIRQ_n = penIrq_n;

endmodule

// File: tb/tb_adc_touch_responder.sv
// Self-checking bench for adc_touch_responder: a bit-banged controller drives
// frames, expected DOUT/BUSY per DCLK rise are queued and checked at each rise.
module tb_adc_touch_responder;
  localparam int SYNC = 2;

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b0;
  logic        iPEN_DOWN = 1'b0;
  logic [11:0] iX_POS = 12'h000;
  logic [11:0] iY_POS = 12'h000;
  logic [7:0]  oCMD;
  logic        oCMD_VALID;

  adc_touch_if adcBus ();

  adc_touch_responder #(.SYNC_STAGES(SYNC)) dut (
    .iCLK       (iCLK),
    .iRST_n     (iRST_n),
    .adc        (adcBus),
    .iPEN_DOWN  (iPEN_DOWN),
    .iX_POS     (iX_POS),
    .iY_POS     (iY_POS),
    .oCMD       (oCMD),
    .oCMD_VALID (oCMD_VALID)
  );

  always #5 iCLK = ~iCLK;

  int assertCount = 0;
  int errCount    = 0;

  typedef struct {int rise; logic dout; logic busy;} exp_t;
  typedef struct {int rise; logic pen;} pen_t;
  exp_t sbq[$];
  pen_t penq[$];

  // Counts oCMD_VALID pulses and any pulse that lasts more than one cycle.
  int         validCount = 0;
  int         validWide  = 0;
  logic [7:0] validCmd   = 8'h00;
  logic       validPrev  = 1'b0;
  always @(posedge iCLK) begin
    validPrev <= oCMD_VALID;
    if (oCMD_VALID) begin
      validCount <= validCount + 1;
      validCmd   <= oCMD;
      if (validPrev) validWide <= validWide + 1;
    end
  end

  function automatic logic [11:0] exp_data(input logic [7:0] cmd, input logic [11:0] x,
                                           input logic [11:0] y);
    logic [11:0] d;
    case (cmd[6:4])
      3'b001:  d = x;
      3'b101:  d = y;
      default: d = 12'h000;
    endcase
    if (cmd[3]) d = {d[11:4], 4'h0};
    return d;
  endfunction

  function automatic logic din_for(input int r, input logic [7:0] c1, input logic [7:0] c2,
                                   input int s2);
    if (r >= 1 && r <= 8) return c1[8-r];
    if (s2 > 0 && r >= s2 && r <= s2 + 7) return c2[s2+7-r];
    return 1'b0;
  endfunction

  // Queue what the master should see on each rise for a command captured at capRise.
  task automatic push_frame(input logic [7:0] cmd, input logic [11:0] x, input logic [11:0] y,
                            input int firstRise, input int capRise, input int lastRise);
    int n;
    logic [11:0] d;
    n = cmd[3] ? 8 : 12;
    d = exp_data(cmd, x, y);
    for (int r = firstRise; r <= lastRise; r++) begin
      exp_t e;
      e.rise = r;
      e.busy = (r == capRise + 1);
      e.dout = 1'b0;
      if (r >= capRise + 2 && r < capRise + 2 + n) e.dout = d[11-(r-capRise-2)];
      sbq.push_back(e);
    end
  endtask

  // One DCLK period: DIN set after the fall, outputs sampled just before the rise.
  task automatic tick(input logic dinv, input int r, input int half);
    adcBus.ADC_DIN = dinv;
    repeat (half) @(negedge iCLK);
    while (sbq.size() > 0 && sbq[0].rise == r) begin
      exp_t e;
      e = sbq.pop_front();
      assertCount++;
      if ({adcBus.ADC_DOUT, adcBus.ADC_BUSY} !== {e.dout, e.busy}) begin
        errCount++;
        $display("FAIL rise%0d dout/busy: got %b/%b expected %b/%b", r,
                 adcBus.ADC_DOUT, adcBus.ADC_BUSY, e.dout, e.busy);
      end
    end
    while (penq.size() > 0 && penq[0].rise == r) begin
      pen_t p;
      p = penq.pop_front();
      assertCount++;
      if (adcBus.ADC_PENIRQ_n !== p.pen) begin
        errCount++;
        $display("FAIL rise%0d penirq_n: got %b expected %b", r, adcBus.ADC_PENIRQ_n, p.pen);
      end
    end
    adcBus.ADC_DCLK = 1'b1;
    repeat (half) @(negedge iCLK);
    adcBus.ADC_DCLK = 1'b0;
  endtask

  task automatic cs_on();
    adcBus.ADC_CS = 1'b1;
    repeat (4) @(negedge iCLK);
  endtask

  task automatic cs_off();
    adcBus.ADC_CS   = 1'b0;
    adcBus.ADC_DCLK = 1'b0;
    adcBus.ADC_DIN  = 1'b0;
    repeat (6) @(negedge iCLK);
  endtask

  task automatic run_frame(input logic [7:0] c1, input logic [7:0] c2, input int s2,
                           input int nrises, input int half);
    cs_on();
    for (int r = 1; r <= nrises; r++) tick(din_for(r, c1, c2, s2), r, half);
  endtask

  task automatic drain_check(input string name);
    assertCount++;
    if (sbq.size() != 0 || penq.size() != 0) begin
      errCount++;
      $display("FAIL %s scoreboard: got %0d/%0d leftover entries expected 0/0", name,
               sbq.size(), penq.size());
    end
    sbq.delete();
    penq.delete();
  endtask

  task automatic test_reset();
    iRST_n = 1'b0;
    adcBus.ADC_CS = 1'b0; adcBus.ADC_DCLK = 1'b0; adcBus.ADC_DIN = 1'b0;
    repeat (3) @(negedge iCLK);
    assertCount += 5;
    if (adcBus.ADC_DOUT !== 1'b0) begin errCount++; $display("FAIL reset dout: got %b expected 0", adcBus.ADC_DOUT); end
    if (adcBus.ADC_BUSY !== 1'b0) begin errCount++; $display("FAIL reset busy: got %b expected 0", adcBus.ADC_BUSY); end
    if (adcBus.ADC_PENIRQ_n !== 1'b1) begin errCount++; $display("FAIL reset penirq_n: got %b expected 1", adcBus.ADC_PENIRQ_n); end
    if (oCMD !== 8'h00) begin errCount++; $display("FAIL reset cmd: got %h expected 00", oCMD); end
    if (oCMD_VALID !== 1'b0) begin errCount++; $display("FAIL reset cmd_valid: got %b expected 0", oCMD_VALID); end
    iRST_n = 1'b1;
    repeat (3) @(negedge iCLK);
  endtask

  task automatic test_basic_12bit();
    int v0;
    v0 = validCount;
    iX_POS = 12'hA5C;
    push_frame(8'h92, iX_POS, iY_POS, 1, 8, 23);
    run_frame(8'h92, 8'h00, 0, 23, 715);
    drain_check("basic");
    assertCount += 3;
    if (oCMD !== 8'h92) begin errCount++; $display("FAIL basic cmd: got %h expected 92", oCMD); end
    if (validCount - v0 !== 1) begin errCount++; $display("FAIL basic valid_count: got %0d expected 1", validCount - v0); end
    if (validWide !== 0) begin errCount++; $display("FAIL basic valid_width: got %0d long pulses expected 0", validWide); end
    cs_off();
  endtask

  task automatic test_overlap();
    int v0;
    v0 = validCount;
    iX_POS = 12'h123;
    iY_POS = 12'hFED;
    push_frame(8'h92, iX_POS, iY_POS, 1, 8, 24);
    push_frame(8'hD2, iX_POS, iY_POS, 25, 24, 38);
    run_frame(8'h92, 8'hD2, 17, 38, 10);
    drain_check("overlap");
    assertCount += 3;
    if (validCount - v0 !== 2) begin errCount++; $display("FAIL overlap valid_count: got %0d expected 2", validCount - v0); end
    if (validCmd !== 8'hD2) begin errCount++; $display("FAIL overlap last_valid_cmd: got %h expected d2", validCmd); end
    if (validWide !== 0) begin errCount++; $display("FAIL overlap valid_width: got %0d long pulses expected 0", validWide); end
    cs_off();
  endtask

  task automatic test_8bit_and_unknown();
    iX_POS = 12'hABC;
    iY_POS = 12'h777;
    push_frame(8'h9A, iX_POS, iY_POS, 1, 8, 20);
    run_frame(8'h9A, 8'h00, 0, 20, 10);
    drain_check("mode8");
    assertCount++;
    if (oCMD !== 8'h9A) begin errCount++; $display("FAIL mode8 cmd: got %h expected 9a", oCMD); end
    cs_off();
    push_frame(8'hB2, iX_POS, iY_POS, 1, 8, 22);
    run_frame(8'hB2, 8'h00, 0, 22, 10);
    drain_check("unknown_chan");
    assertCount++;
    if (oCMD !== 8'hB2) begin errCount++; $display("FAIL unknown_chan cmd: got %h expected b2", oCMD); end
    cs_off();
  endtask

  task automatic test_penirq();
    iPEN_DOWN = 1'b1;
    repeat (3) @(negedge iCLK);
    assertCount++;
    if (adcBus.ADC_PENIRQ_n !== 1'b0) begin errCount++; $display("FAIL pen_idle penirq_n: got %b expected 0", adcBus.ADC_PENIRQ_n); end
    iX_POS = 12'h5A5;
    penq.push_back('{5, 1'b1});
    penq.push_back('{15, 1'b1});
    push_frame(8'h92, iX_POS, iY_POS, 1, 8, 23);
    run_frame(8'h92, 8'h00, 0, 23, 10);
    drain_check("pen_active");
    repeat (4) @(negedge iCLK);
    assertCount++;
    if (adcBus.ADC_PENIRQ_n !== 1'b0) begin errCount++; $display("FAIL pen_tail penirq_n: got %b expected 0", adcBus.ADC_PENIRQ_n); end
    cs_off();
    push_frame(8'h93, iX_POS, iY_POS, 1, 8, 23);
    run_frame(8'h93, 8'h00, 0, 23, 10);
    drain_check("pen_pd0");
    cs_off();
    assertCount++;
    if (adcBus.ADC_PENIRQ_n !== 1'b1) begin errCount++; $display("FAIL pen_disabled penirq_n: got %b expected 1", adcBus.ADC_PENIRQ_n); end
    run_frame(8'h92, 8'h00, 0, 23, 10);
    cs_off();
    assertCount++;
    if (adcBus.ADC_PENIRQ_n !== 1'b0) begin errCount++; $display("FAIL pen_reenabled penirq_n: got %b expected 0", adcBus.ADC_PENIRQ_n); end
    iPEN_DOWN = 1'b0;
    repeat (3) @(negedge iCLK);
  endtask

  task automatic test_deselect();
    int v0;
    iX_POS = 12'hFFF;
    push_frame(8'h92, iX_POS, iY_POS, 1, 8, 14);
    run_frame(8'h92, 8'h00, 0, 14, 10);
    drain_check("desel_pre");
    adcBus.ADC_DIN = 1'b0;
    repeat (10) @(negedge iCLK);
    assertCount++;
    if (adcBus.ADC_DOUT !== 1'b1) begin errCount++; $display("FAIL desel_before dout: got %b expected 1", adcBus.ADC_DOUT); end
    adcBus.ADC_CS = 1'b0;
    repeat (SYNC + 1) @(negedge iCLK);
    assertCount += 2;
    if (adcBus.ADC_DOUT !== 1'b0) begin errCount++; $display("FAIL desel_after dout: got %b expected 0", adcBus.ADC_DOUT); end
    if (adcBus.ADC_BUSY !== 1'b0) begin errCount++; $display("FAIL desel_after busy: got %b expected 0", adcBus.ADC_BUSY); end
    cs_off();
    v0 = validCount;
    cs_on();
    for (int r = 1; r <= 4; r++) tick(din_for(r, 8'h92, 8'h00, 0), r, 10);
    cs_off();
    assertCount++;
    if (validCount !== v0) begin errCount++; $display("FAIL desel_midbyte valid_count: got %0d expected %0d", validCount, v0); end
    iX_POS = 12'h3C5;
    push_frame(8'h92, iX_POS, iY_POS, 1, 8, 23);
    run_frame(8'h92, 8'h00, 0, 23, 10);
    drain_check("desel_next");
    cs_off();
  endtask

  task automatic test_reset_midshift();
    iX_POS = 12'hFFF;
    push_frame(8'h92, iX_POS, iY_POS, 1, 8, 12);
    run_frame(8'h92, 8'h00, 0, 12, 10);
    drain_check("rst_pre");
    adcBus.ADC_DIN = 1'b0;
    repeat (10) @(negedge iCLK);
    assertCount++;
    if (adcBus.ADC_DOUT !== 1'b1) begin errCount++; $display("FAIL rst_before dout: got %b expected 1", adcBus.ADC_DOUT); end
    iRST_n = 1'b0;
    #1;
    assertCount += 5;
    if (adcBus.ADC_DOUT !== 1'b0) begin errCount++; $display("FAIL rst_mid dout: got %b expected 0", adcBus.ADC_DOUT); end
    if (adcBus.ADC_BUSY !== 1'b0) begin errCount++; $display("FAIL rst_mid busy: got %b expected 0", adcBus.ADC_BUSY); end
    if (adcBus.ADC_PENIRQ_n !== 1'b1) begin errCount++; $display("FAIL rst_mid penirq_n: got %b expected 1", adcBus.ADC_PENIRQ_n); end
    if (oCMD !== 8'h00) begin errCount++; $display("FAIL rst_mid cmd: got %h expected 00", oCMD); end
    if (oCMD_VALID !== 1'b0) begin errCount++; $display("FAIL rst_mid cmd_valid: got %b expected 0", oCMD_VALID); end
    repeat (2) @(negedge iCLK);
    iRST_n = 1'b1;
    cs_off();
    iX_POS = 12'h5A3;
    push_frame(8'h92, iX_POS, iY_POS, 1, 8, 23);
    run_frame(8'h92, 8'h00, 0, 23, 10);
    drain_check("rst_next");
    assertCount++;
    if (oCMD !== 8'h92) begin errCount++; $display("FAIL rst_next cmd: got %h expected 92", oCMD); end
    cs_off();
  endtask

  initial begin
    test_reset();
    test_basic_12bit();
    test_overlap();
    test_8bit_and_unknown();
    test_penirq();
    test_deselect();
    test_reset_midshift();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, errCount);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
